// File: rtl/game_pkg.sv
// Shared game definitions: top-level game state encoding, progress phase
// enum and the lives/level port widths. Used by the game FSM, the HUD and
// game_progress.
package game_pkg;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        GAME_INITIAL = 2'b00,
        GAME_RUNNING = 2'b01,
        GAME_OVER    = 2'b10
    } game_state_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        DYING = 2'b01,
        DONE  = 2'b10
    } phase_t;

    // Width of a down/up counter able to hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            cnt_width = $clog2(n);
        end else begin
            cnt_width = 1;
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV enabled
// cycles. The counter only advances while en is high and is forced back to
// zero by the synchronous clear. The tick is a decode of the registered
// count so the consumer sees it in the same cycle the wrap happens.
module tick_gen
    import game_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Prescaler count: clear has priority, then advance and wrap while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & (cnt_r == CNT_LAST);

endmodule

// File: rtl/game_progress.sv
// Per-game progress tracker: lives, bonus countdown, level and score.
// Runs a PLAY/DYING/DONE phase machine while the game is RUNNING, reloads
// start-of-game values in INITIAL and freezes everything in OVER.
// Optional feature: define EXTRA_LIFE_EN to award one extra life per game
// when the score first reaches EXTRA_LIFE_SCORE.
module game_progress
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BONUS_W    = 14,
    parameter int BONUS_INIT = 5000,
    parameter int BONUS_STEP = 100,
    parameter int LIVES_INIT = 3,
    parameter int LIVES_MAX  = 7,
    parameter int DIE_CYCLES = 100_000_000,
    parameter int SCORE_W    = 20,
`ifdef EXTRA_LIFE_EN
    parameter int EXTRA_LIFE_SCORE = 10000,
`endif
    parameter int LEVEL_MAX  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         state,
    input  logic               hit,
    input  logic               goal,
    output logic [LIVES_W-1:0] lives,
    output logic [BONUS_W-1:0] bonus,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score,
    output logic               dying,
    output logic               respawn,
    output logic               over
);

    localparam int DW = cnt_width(DIE_CYCLES);

    // Start-of-game lives never exceed the ceiling.
    localparam int LIVES_START = (LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT;

    localparam logic [LIVES_W-1:0] LIVES_INIT_V = LIVES_W'(LIVES_START);
    localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
    localparam logic [BONUS_W-1:0] BONUS_INIT_V = BONUS_W'(BONUS_INIT);
    localparam logic [BONUS_W-1:0] BONUS_STEP_V = BONUS_W'(BONUS_STEP);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX_V  = LEVEL_W'(LEVEL_MAX);
    localparam logic [DW-1:0]      DIE_LOAD     = DW'(DIE_CYCLES - 1);
    localparam logic [DW-1:0]      DLY_ONE      = DW'(1);
`ifdef EXTRA_LIFE_EN
    localparam logic [LIVES_W-1:0] LIVES_MAX_V  = LIVES_W'(LIVES_MAX);
    localparam logic [SCORE_W-1:0] EXTRA_V      = SCORE_W'(EXTRA_LIFE_SCORE);
`endif

    // Registered state
    phase_t             phase_r;
    logic [LIVES_W-1:0] lives_r;
    logic [BONUS_W-1:0] bonus_r;
    logic [LEVEL_W-1:0] level_r;
    logic [SCORE_W-1:0] score_r;
    logic               dying_r;
    logic               respawn_r;
    logic               over_r;
    logic [DW-1:0]      delay_r;

    // Next-state values
    phase_t             phase_s;
    logic [LIVES_W-1:0] lives_s;
    logic [BONUS_W-1:0] bonus_s;
    logic [LEVEL_W-1:0] level_s;
    logic [SCORE_W-1:0] score_s;
    logic               dying_s;
    logic               respawn_s;
    logic               over_s;
    logic [DW-1:0]      delay_s;

    // Datapath helpers
    logic               tick_s;
    logic               tick_en_s;
    logic               tick_clr_s;
    logic               death_s;
    logic [BONUS_W-1:0] bonus_dec_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [SCORE_W-1:0] score_sat_s;

`ifdef EXTRA_LIFE_EN
    logic               extra_done_r;
    logic               extra_done_s;
`endif

    // Bonus only counts down while actually playing a running game.
    assign tick_en_s = (state == GAME_RUNNING) && (phase_r == PLAY);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_s),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Saturating arithmetic shared by the phase logic.
    always_comb begin
        bonus_dec_s = '0;
        score_sum_s = '0;
        score_sat_s = '0;
        if (bonus_r > BONUS_STEP_V) begin
            bonus_dec_s = bonus_r - BONUS_STEP_V;
        end else begin
            bonus_dec_s = '0;
        end
        score_sum_s = {1'b0, score_r} + (SCORE_W + 1)'(bonus_r);
        if (score_sum_s[SCORE_W]) begin
            score_sat_s = '1;
        end else begin
            score_sat_s = score_sum_s[SCORE_W-1:0];
        end
    end

    // Phase machine and counter next-state logic.
    always_comb begin
        phase_s    = phase_r;
        lives_s    = lives_r;
        bonus_s    = bonus_r;
        level_s    = level_r;
        score_s    = score_r;
        dying_s    = dying_r;
        respawn_s  = 1'b0;
        over_s     = over_r;
        delay_s    = delay_r;
        tick_clr_s = 1'b0;
        death_s    = 1'b0;
`ifdef EXTRA_LIFE_EN
        extra_done_s = extra_done_r;
`endif

        case (state)
            GAME_INITIAL: begin
                phase_s    = PLAY;
                lives_s    = LIVES_INIT_V;
                bonus_s    = BONUS_INIT_V;
                level_s    = LEVEL_ONE;
                score_s    = '0;
                dying_s    = 1'b0;
                over_s     = 1'b0;
                delay_s    = '0;
                tick_clr_s = 1'b1;
`ifdef EXTRA_LIFE_EN
                extra_done_s = 1'b0;
`endif
            end
            GAME_RUNNING: begin
                case (phase_r)
                    PLAY: begin
                        // A hit and a bonus-exhausting tick together still cost one life.
                        death_s = hit | (tick_s & (bonus_dec_s == '0));
                        if (tick_s) begin
                            bonus_s = bonus_dec_s;
                        end else begin
                            bonus_s = bonus_r;
                        end
                        if (death_s) begin
                            if (lives_r > LIVES_ONE) begin
                                lives_s = lives_r - LIVES_ONE;
                                dying_s = 1'b1;
                                delay_s = DIE_LOAD;
                                phase_s = DYING;
                            end else begin
                                lives_s = '0;
                                over_s  = 1'b1;
                                phase_s = DONE;
                            end
                        end else if (goal) begin
                            score_s    = score_sat_s;
                            bonus_s    = BONUS_INIT_V;
                            tick_clr_s = 1'b1;
                            if (level_r < LEVEL_MAX_V) begin
                                level_s = level_r + LEVEL_ONE;
                            end else begin
                                level_s = level_r;
                            end
`ifdef EXTRA_LIFE_EN
                            if (!extra_done_r && (score_r < EXTRA_V) && (score_sat_s >= EXTRA_V)) begin
                                extra_done_s = 1'b1;
                                if (lives_r < LIVES_MAX_V) begin
                                    lives_s = lives_r + LIVES_ONE;
                                end else begin
                                    lives_s = lives_r;
                                end
                            end else begin
                                extra_done_s = extra_done_r;
                            end
`endif
                        end else begin
                            phase_s = PLAY;
                        end
                    end
                    DYING: begin
                        // Inputs and ticks are ignored until the hold expires.
                        if (delay_r == '0) begin
                            dying_s    = 1'b0;
                            respawn_s  = 1'b1;
                            bonus_s    = BONUS_INIT_V;
                            tick_clr_s = 1'b1;
                            phase_s    = PLAY;
                        end else begin
                            delay_s = delay_r - DLY_ONE;
                        end
                    end
                    DONE: begin
                        phase_s = DONE;
                    end
                    default: begin
                        phase_s = PLAY;
                    end
                endcase
            end
            GAME_OVER: begin
                phase_s = phase_r;
            end
            default: begin
                phase_s = phase_r;
            end
        endcase
    end

    // Progress registers; reset loads the start-of-game values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r   <= PLAY;
            lives_r   <= LIVES_INIT_V;
            bonus_r   <= BONUS_INIT_V;
            level_r   <= LEVEL_ONE;
            score_r   <= '0;
            dying_r   <= 1'b0;
            respawn_r <= 1'b0;
            over_r    <= 1'b0;
            delay_r   <= '0;
        end else begin
            phase_r   <= phase_s;
            lives_r   <= lives_s;
            bonus_r   <= bonus_s;
            level_r   <= level_s;
            score_r   <= score_s;
            dying_r   <= dying_s;
            respawn_r <= respawn_s;
            over_r    <= over_s;
            delay_r   <= delay_s;
        end
    end

`ifdef EXTRA_LIFE_EN
    // Once-per-game extra-life award flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extra_done_r <= 1'b0;
        end else begin
            extra_done_r <= extra_done_s;
        end
    end
`endif

    assign lives   = lives_r;
    assign bonus   = bonus_r;
    assign level   = level_r;
    assign score   = score_r;
    assign dying   = dying_r;
    assign respawn = respawn_r;
    assign over    = over_r;

endmodule

// File: tb/tb_game_progress.sv
// Directed bench for game_progress with small simulation parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_game_progress;
    import game_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         state;
    logic               hit;
    logic               goal;
    logic [LIVES_W-1:0] lives;
    logic [13:0]        bonus;
    logic [LEVEL_W-1:0] level;
    logic [19:0]        score;
    logic               dying;
    logic               respawn;
    logic               over;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    game_progress #(
        .TICK_DIV   (4),
        .BONUS_W    (14),
        .BONUS_INIT (20),
        .BONUS_STEP (5),
        .LIVES_INIT (3),
        .LIVES_MAX  (7),
        .DIE_CYCLES (3),
        .SCORE_W    (20),
`ifdef EXTRA_LIFE_EN
        .EXTRA_LIFE_SCORE (30),
`endif
        .LEVEL_MAX  (15)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .hit     (hit),
        .goal    (goal),
        .lives   (lives),
        .bonus   (bonus),
        .level   (level),
        .score   (score),
        .dying   (dying),
        .respawn (respawn),
        .over    (over)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        state = GAME_INITIAL;
        hit   = 1'b0;
        goal  = 1'b0;
        step(2);
        check_val("rst_lives",   32'(lives),   32'd3);
        check_val("rst_bonus",   32'(bonus),   32'd20);
        check_val("rst_level",   32'(level),   32'd1);
        check_val("rst_score",   32'(score),   32'd0);
        check_val("rst_dying",   32'(dying),   32'd0);
        check_val("rst_respawn", 32'(respawn), 32'd0);
        check_val("rst_over",    32'(over),    32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: bonus countdown to zero costs a life
        state = GAME_RUNNING;
        for (int k = 1; k <= 3; k++) begin
            step(4);
            check_val("t1_bonus", 32'(bonus), 32'(20 - 5 * k));
        end
        step(4);
        check_val("t1_bonus0", 32'(bonus), 32'd0);
        check_val("t1_lives",  32'(lives), 32'd2);
        check_val("t1_dying",  32'(dying), 32'd1);
        state = GAME_INITIAL;
        step(1);
        check_val("t1_init_lives", 32'(lives), 32'd3);
        check_val("t1_init_bonus", 32'(bonus), 32'd20);

        // 2: hit, death hold, hit ignored while dying, respawn
        state = GAME_RUNNING;
        step(1);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check_val("t2_lives", 32'(lives), 32'd2);
        check_val("t2_dying", 32'(dying), 32'd1);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check_val("t2_hit_ignored", 32'(lives), 32'd2);
        check_val("t2_dying2",      32'(dying), 32'd1);
        step(1);
        check_val("t2_dying3",   32'(dying),   32'd1);
        check_val("t2_norespawn", 32'(respawn), 32'd0);
        step(1);
        check_val("t2_dying_end", 32'(dying),   32'd0);
        check_val("t2_respawn",   32'(respawn), 32'd1);
        check_val("t2_bonus",     32'(bonus),   32'd20);
        step(1);
        check_val("t2_respawn_pulse", 32'(respawn), 32'd0);

        // 3: three hits run out of lives
        state = GAME_INITIAL;
        step(1);
        state = GAME_RUNNING;
        step(1);
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1;
            step(1);
            hit = 1'b0;
            if (i < 2) begin
                check_val("t3_lives", 32'(lives), 32'(2 - i));
                step(3);
                check_val("t3_respawn", 32'(respawn), 32'd1);
                step(1);
            end else begin
                check_val("t3_lives0", 32'(lives), 32'd0);
                check_val("t3_over",   32'(over),  32'd1);
                check_val("t3_nodie",  32'(dying), 32'd0);
            end
        end
        state = GAME_OVER;
        step(3);
        check_val("t3_over_hold",  32'(over),  32'd1);
        check_val("t3_lives_hold", 32'(lives), 32'd0);
        state = GAME_INITIAL;
        step(1);
        check_val("t3_over_clr",  32'(over),  32'd0);
        check_val("t3_lives_rld", 32'(lives), 32'd3);

        // 4: goal scores the bonus; hit beats a simultaneous goal
        state = GAME_RUNNING;
        step(5);
        check_val("t4_bonus15", 32'(bonus), 32'd15);
        goal = 1'b1;
        step(1);
        goal = 1'b0;
        check_val("t4_score", 32'(score), 32'd15);
        check_val("t4_level", 32'(level), 32'd2);
        check_val("t4_bonus", 32'(bonus), 32'd20);
        check_val("t4_lives", 32'(lives), 32'd3);
        hit  = 1'b1;
        goal = 1'b1;
        step(1);
        hit  = 1'b0;
        goal = 1'b0;
        check_val("t4_hg_lives", 32'(lives), 32'd2);
        check_val("t4_hg_score", 32'(score), 32'd15);
        check_val("t4_hg_level", 32'(level), 32'd2);
        check_val("t4_hg_dying", 32'(dying), 32'd1);

        // 5: return to INITIAL mid-hold aborts without respawn
        state = GAME_INITIAL;
        step(1);
        check_val("t5_lives", 32'(lives), 32'd3);
        check_val("t5_dying", 32'(dying), 32'd0);
        check_val("t5_score", 32'(score), 32'd0);
        check_val("t5_level", 32'(level), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_val("t5_no_respawn", 32'(respawn), 32'd0);
            step(1);
        end

        // 6: extra life once when score crosses 30 (only with EXTRA_LIFE_EN)
        state = GAME_RUNNING;
        goal  = 1'b1;
        step(1);
        goal  = 1'b0;
        check_val("t6_score20", 32'(score), 32'd20);
        check_val("t6_lives_a", 32'(lives), 32'd3);
        step(4);
        check_val("t6_bonus15", 32'(bonus), 32'd15);
        goal = 1'b1;
        step(1);
        goal = 1'b0;
        check_val("t6_score35", 32'(score), 32'd35);
        check_val("t6_level3",  32'(level), 32'd3);
`ifdef EXTRA_LIFE_EN
        check_val("t6_award", 32'(lives), 32'd4);
`else
        check_val("t6_award", 32'(lives), 32'd3);
`endif
        goal = 1'b1;
        step(1);
        goal = 1'b0;
        check_val("t6_score55", 32'(score), 32'd55);
        check_val("t6_level4",  32'(level), 32'd4);
`ifdef EXTRA_LIFE_EN
        check_val("t6_once", 32'(lives), 32'd4);
`else
        check_val("t6_once", 32'(lives), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
